// File: rtl/cache_rd_arbiter.sv
// cache_rd_arbiter: shares the bridge refill read channel between icache (id 0) and dcache (id 1)
module cache_rd_arbiter #(
   parameter int LINE_OFF_BITS = 4,
   parameter int STARVE_LIMIT  = 4
) (
   input  logic        aclk,
   input  logic        aresetn,
   input  logic        icache_rd_req,
   input  logic [2:0]  icache_rd_type,
   input  logic [31:0] icache_rd_addr,
   output logic        icache_rd_rdy,
   output logic        icache_ret_valid,
   output logic        icache_ret_last,
   output logic [31:0] icache_ret_data,
   input  logic        dcache_rd_req,
   input  logic [2:0]  dcache_rd_type,
   input  logic [31:0] dcache_rd_addr,
   output logic        dcache_rd_rdy,
   output logic        dcache_ret_valid,
   output logic        dcache_ret_last,
   output logic [31:0] dcache_ret_data,
   output logic        br_rd_req,
   output logic [3:0]  br_rd_id,
   output logic [2:0]  br_rd_type,
   output logic [31:0] br_rd_addr,
   input  logic        br_rd_rdy,
   input  logic        br_ret_valid,
   input  logic        br_ret_last,
   input  logic [3:0]  br_ret_id,
   input  logic [31:0] br_ret_data,
   input  logic        wr_busy,
   input  logic [31:0] wr_addr,
   output logic        proto_err
);
   typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
   localparam logic [31:0] LINE_MASK = ~((32'd1 << LINE_OFF_BITS) - 32'd1);
   localparam logic [3:0]  LIMIT     = 4'(STARVE_LIMIT);
   state_t      state, state_nxt;
   logic [3:0]  starve_cnt, lat_id;
   logic [2:0]  lat_type, beat_cnt;
   logic [31:0] lat_addr;
   logic        i_conf, d_conf, gnt_d, ovf, beat_ok, done, bad;
   always_comb begin
      i_conf           = wr_busy & (((icache_rd_addr ^ wr_addr) & LINE_MASK) == 32'd0);
      d_conf           = wr_busy & (((dcache_rd_addr ^ wr_addr) & LINE_MASK) == 32'd0);
      gnt_d            = dcache_rd_req & ~(icache_rd_req & (starve_cnt == LIMIT));
      dcache_rd_rdy    = aresetn & (state == IDLE) & gnt_d & ~d_conf;
      icache_rd_rdy    = aresetn & (state == IDLE) & ~gnt_d & icache_rd_req & ~i_conf;
      ovf              = (beat_cnt == 3'd4) & ~br_ret_last;
      beat_ok          = (state == WAIT) & br_ret_valid & (br_ret_id == lat_id) & ~ovf;
      done             = beat_ok & br_ret_last;
      bad              = (br_ret_valid & ~beat_ok) |
                         (done & (beat_cnt != ((lat_type == 3'b100) ? 3'd3 : 3'd0)));
      icache_ret_valid = beat_ok & ~lat_id[0];
      dcache_ret_valid = beat_ok & lat_id[0];
      icache_ret_last  = icache_ret_valid & br_ret_last;
      dcache_ret_last  = dcache_ret_valid & br_ret_last;
      icache_ret_data  = icache_ret_valid ? br_ret_data : 32'd0;
      dcache_ret_data  = dcache_ret_valid ? br_ret_data : 32'd0;
      br_rd_req        = (state == REQ);
      br_rd_id         = lat_id;
      br_rd_type       = lat_type;
      br_rd_addr       = lat_addr;
   end
   always_comb begin
      state_nxt = state;
      state_nxt = (state == IDLE) ? ((icache_rd_rdy | dcache_rd_rdy) ? REQ : IDLE) :
                  (state == REQ)  ? (br_rd_rdy ? WAIT : REQ) :
                                    (done ? IDLE : WAIT);
   end
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state      <= IDLE;
         starve_cnt <= 4'd0;
         lat_id     <= 4'd0;
         lat_type   <= 3'd0;
         lat_addr   <= 32'd0;
         beat_cnt   <= 3'd0;
         proto_err  <= 1'b0;
      end else begin
         state     <= state_nxt;
         proto_err <= proto_err | bad;
         if (icache_rd_rdy | dcache_rd_rdy) begin
            lat_addr <= dcache_rd_rdy ? dcache_rd_addr : icache_rd_addr;
            lat_type <= dcache_rd_rdy ? dcache_rd_type : icache_rd_type;
            lat_id   <= {3'd0, dcache_rd_rdy};
            beat_cnt <= 3'd0;
         end else if (beat_ok) begin
            beat_cnt <= beat_cnt + 3'd1;
         end
         // the counter only tracks dcache wins that actually made the icache wait
         starve_cnt <= icache_rd_rdy ? 4'd0 :
                       (dcache_rd_rdy & icache_rd_req & (starve_cnt != LIMIT)) ? starve_cnt + 4'd1 :
                       starve_cnt;
      end
   end
endmodule

// File: tb/tb_cache_rd_arbiter.sv
// tb_cache_rd_arbiter: directed scenarios plus randomized traffic against a transaction-level model
module tb_cache_rd_arbiter;
   localparam int LOB = 4;
   localparam int SL  = 4;
   logic        aclk = 1'b0, aresetn = 1'b0;
   logic        icache_rd_req, icache_rd_rdy, icache_ret_valid, icache_ret_last;
   logic [2:0]  icache_rd_type;
   logic [31:0] icache_rd_addr, icache_ret_data;
   logic        dcache_rd_req, dcache_rd_rdy, dcache_ret_valid, dcache_ret_last;
   logic [2:0]  dcache_rd_type;
   logic [31:0] dcache_rd_addr, dcache_ret_data;
   logic        br_rd_req, br_rd_rdy, br_ret_valid, br_ret_last, wr_busy, proto_err;
   logic [3:0]  br_rd_id, br_ret_id;
   logic [2:0]  br_rd_type;
   logic [31:0] br_rd_addr, br_ret_data, wr_addr;
   cache_rd_arbiter #(.LINE_OFF_BITS(LOB), .STARVE_LIMIT(SL)) dut (
      .aclk(aclk), .aresetn(aresetn),
      .icache_rd_req(icache_rd_req), .icache_rd_type(icache_rd_type), .icache_rd_addr(icache_rd_addr),
      .icache_rd_rdy(icache_rd_rdy), .icache_ret_valid(icache_ret_valid), .icache_ret_last(icache_ret_last),
      .icache_ret_data(icache_ret_data),
      .dcache_rd_req(dcache_rd_req), .dcache_rd_type(dcache_rd_type), .dcache_rd_addr(dcache_rd_addr),
      .dcache_rd_rdy(dcache_rd_rdy), .dcache_ret_valid(dcache_ret_valid), .dcache_ret_last(dcache_ret_last),
      .dcache_ret_data(dcache_ret_data),
      .br_rd_req(br_rd_req), .br_rd_id(br_rd_id), .br_rd_type(br_rd_type), .br_rd_addr(br_rd_addr),
      .br_rd_rdy(br_rd_rdy), .br_ret_valid(br_ret_valid), .br_ret_last(br_ret_last), .br_ret_id(br_ret_id),
      .br_ret_data(br_ret_data), .wr_busy(wr_busy), .wr_addr(wr_addr), .proto_err(proto_err)
   );
   always #5 aclk = ~aclk;
   int n_vec = 0, n_err = 0;
   bit          m_busy, m_issued, m_err, e_irdy, e_drdy, e_hit;
   int          m_beats, m_starve;
   logic [3:0]  m_id;
   logic [2:0]  m_type;
   logic [31:0] m_addr;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask
   function automatic bit blocked(input logic [31:0] a);
      return wr_busy && ((a >> LOB) == (wr_addr >> LOB));
   endfunction
   function automatic int beats_of(input logic [2:0] t);
      return (t == 3'b100) ? 4 : 1;
   endfunction
   function automatic logic [31:0] pick_addr();
      logic [31:0] base;
      case ($urandom % 4)
         0: base = 32'h1000;
         1: base = 32'h2000;
         2: base = 32'h3000;
         default: base = $urandom;
      endcase
      return base | 32'($urandom % 16);
   endfunction
   task automatic model_reset;
      m_busy = 0; m_issued = 0; m_err = 0; m_beats = 0; m_starve = 0;
      m_id = 0; m_type = 0; m_addr = 0;
   endtask
   task automatic quiet;
      icache_rd_req = 0; icache_rd_type = 0; icache_rd_addr = 0;
      dcache_rd_req = 0; dcache_rd_type = 0; dcache_rd_addr = 0;
      br_rd_rdy = 0; br_ret_valid = 0; br_ret_last = 0; br_ret_id = 0; br_ret_data = 0;
      wr_busy = 0; wr_addr = 0;
   endtask
   task automatic settle;
      bit win_d, io, do_;
      #1;
      win_d  = dcache_rd_req && !(icache_rd_req && m_starve == SL);
      e_drdy = aresetn && !m_busy && win_d && !blocked(dcache_rd_addr);
      e_irdy = aresetn && !m_busy && icache_rd_req && !win_d && !blocked(icache_rd_addr);
      e_hit  = m_busy && m_issued && br_ret_valid && br_ret_id == m_id && !(m_beats == 4 && !br_ret_last);
      io     = e_hit && m_id == 0;
      do_    = e_hit && m_id == 1;
      chk("irdy", icache_rd_rdy, e_irdy);
      chk("drdy", dcache_rd_rdy, e_drdy);
      chk("br_req", br_rd_req, m_busy && !m_issued);
      chk("br_id", br_rd_id, m_id);
      chk("br_type", br_rd_type, m_type);
      chk("br_addr", br_rd_addr, m_addr);
      chk("i_ret", {icache_ret_valid, icache_ret_last}, {io, io && br_ret_last});
      chk("d_ret", {dcache_ret_valid, dcache_ret_last}, {do_, do_ && br_ret_last});
      chk("i_data", icache_ret_data, io ? br_ret_data : 32'd0);
      chk("d_data", dcache_ret_data, do_ ? br_ret_data : 32'd0);
      chk("perr", proto_err, m_err);
   endtask
   task automatic adv;
      @(posedge aclk);
      if (br_ret_valid && !e_hit) m_err = 1;
      if (e_hit && br_ret_last && m_beats != beats_of(m_type) - 1) m_err = 1;
      if (e_irdy || e_drdy) begin
         if (e_drdy && icache_rd_req && m_starve < SL) m_starve++;
         if (e_irdy) m_starve = 0;
         m_busy = 1; m_issued = 0; m_beats = 0;
         m_id   = e_drdy ? 4'd1 : 4'd0;
         m_addr = e_drdy ? dcache_rd_addr : icache_rd_addr;
         m_type = e_drdy ? dcache_rd_type : icache_rd_type;
      end else if (m_busy && !m_issued && br_rd_rdy) begin
         m_issued = 1;
      end else if (e_hit) begin
         m_beats++;
         if (br_ret_last) m_busy = 0;
      end
      @(negedge aclk);
   endtask
   task automatic do_reset;
      #1 aresetn = 0;
      #1;
      chk("rst_br", {br_rd_req, br_rd_id, br_rd_type}, 0);
      chk("rst_addr", br_rd_addr, 0);
      chk("rst_ctl", {icache_rd_rdy, dcache_rd_rdy, icache_ret_valid, icache_ret_last,
                      dcache_ret_valid, dcache_ret_last, proto_err}, 0);
      chk("rst_data", icache_ret_data | dcache_ret_data, 0);
      model_reset;
      @(negedge aclk);
      aresetn = 1;
   endtask
   task automatic finish_txn;
      br_rd_rdy = 1; settle; adv;
      br_rd_rdy = 0;
      br_ret_valid = 1; br_ret_id = m_id; br_ret_last = 1; br_ret_data = $urandom;
      settle; adv;
      br_ret_valid = 0; br_ret_last = 0;
   endtask
   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1);
   end
   initial begin
      quiet;
      model_reset;
      @(negedge aclk);
      do_reset;
      // simultaneous requests, dcache line refill, then icache
      icache_rd_req = 1; icache_rd_addr = 32'h1000; icache_rd_type = 3'b000;
      dcache_rd_req = 1; dcache_rd_addr = 32'h2000; dcache_rd_type = 3'b100;
      settle; chk("t1_drdy", dcache_rd_rdy, 1); chk("t1_irdy", icache_rd_rdy, 0); adv;
      dcache_rd_req = 0; br_rd_rdy = 1;
      settle; chk("t1_req", br_rd_req, 1); chk("t1_id", br_rd_id, 1); chk("t1_addr", br_rd_addr, 32'h2000); adv;
      br_rd_rdy = 0;
      for (int k = 0; k < 4; k++) begin
         br_ret_valid = 1; br_ret_id = 1; br_ret_data = 32'hA0 + k; br_ret_last = (k == 3);
         settle;
         chk("t2_dv", dcache_ret_valid, 1);
         chk("t2_dd", dcache_ret_data, 32'hA0 + k);
         chk("t2_dl", dcache_ret_last, (k == 3));
         chk("t2_iv", icache_ret_valid, 0);
         adv;
      end
      br_ret_valid = 0; br_ret_last = 0;
      settle; chk("t1_ilate", icache_rd_rdy, 1); adv;
      icache_rd_req = 0; br_rd_rdy = 1;
      settle; chk("t1_iid", br_rd_id, 0); chk("t1_iaddr", br_rd_addr, 32'h1000); adv;
      br_rd_rdy = 0; br_ret_valid = 1; br_ret_id = 0; br_ret_last = 1; br_ret_data = 32'h55;
      settle; chk("t1_iv", icache_ret_valid, 1); chk("t1_dv", dcache_ret_valid, 0); adv;
      br_ret_valid = 0; br_ret_last = 0;
      settle; chk("t1_perr", proto_err, 0); adv;
      // starvation guard: every fifth grant goes to the icache
      quiet; do_reset;
      icache_rd_req = 1; icache_rd_addr = 32'h1000;
      dcache_rd_req = 1; dcache_rd_addr = 32'h2000;
      for (int g = 0; g < 10; g++) begin
         settle; chk("t3_grant", {icache_rd_rdy, dcache_rd_rdy}, (g % 5 == 4) ? 2'b10 : 2'b01); adv;
         finish_txn;
      end
      // write-back conflict holds off the winner without passing the grant
      quiet; do_reset;
      wr_busy = 1; wr_addr = 32'h2008;
      icache_rd_req = 1; icache_rd_addr = 32'h1000;
      dcache_rd_req = 1; dcache_rd_addr = 32'h3000;
      settle; chk("t4_ok", dcache_rd_rdy, 1); adv;
      finish_txn;
      dcache_rd_addr = 32'h2000;
      for (int k = 0; k < 3; k++) begin
         settle; chk("t4_dblk", dcache_rd_rdy, 0); chk("t4_iblk", icache_rd_rdy, 0); adv;
      end
      wr_busy = 0;
      settle; chk("t4_rel", dcache_rd_rdy, 1); adv;
      finish_txn;
      // wrong-ID beat is dropped and flags a sticky error
      quiet; do_reset;
      dcache_rd_req = 1; dcache_rd_addr = 32'h2000;
      settle; chk("t5_drdy", dcache_rd_rdy, 1); adv;
      dcache_rd_req = 0; br_rd_rdy = 1; settle; adv;
      br_rd_rdy = 0; br_ret_valid = 1; br_ret_id = 0; br_ret_last = 1; br_ret_data = 32'h77;
      settle; chk("t5_dv", dcache_ret_valid, 0); chk("t5_iv", icache_ret_valid, 0); adv;
      br_ret_valid = 0;
      settle; chk("t5_perr", proto_err, 1); adv;
      br_ret_valid = 1; br_ret_id = 1;
      settle; chk("t5_dv2", dcache_ret_valid, 1); chk("t5_dl2", dcache_ret_last, 1); adv;
      br_ret_valid = 0; br_ret_last = 0;
      settle; chk("t5_sticky", proto_err, 1); adv;
      // reset during the third beat of a burst
      quiet; do_reset;
      dcache_rd_req = 1; dcache_rd_addr = 32'h2000; dcache_rd_type = 3'b100;
      settle; adv;
      dcache_rd_req = 0; br_rd_rdy = 1; settle; adv;
      br_rd_rdy = 0;
      for (int k = 0; k < 2; k++) begin
         br_ret_valid = 1; br_ret_id = 1; br_ret_data = 32'hB0 + k; br_ret_last = 0;
         settle; adv;
      end
      br_ret_data = 32'hB2;
      settle; chk("t6_beat2", dcache_ret_valid, 1);
      dcache_rd_req = 1; dcache_rd_addr = 32'h3000;
      do_reset;
      br_ret_valid = 0;
      settle; chk("t6_new", dcache_rd_rdy, 1); adv;
      dcache_rd_req = 0;
      settle; chk("t6_req", br_rd_req, 1); adv;
      // randomized traffic with a misbehaving bridge now and then
      quiet; do_reset;
      for (int c = 0; c < 3000; c++) begin
         icache_rd_req  = ($urandom % 4) != 0;
         dcache_rd_req  = ($urandom % 4) != 0;
         icache_rd_addr = pick_addr();
         dcache_rd_addr = pick_addr();
         icache_rd_type = ($urandom % 2) ? 3'b100 : 3'($urandom);
         dcache_rd_type = ($urandom % 2) ? 3'b100 : 3'($urandom);
         wr_busy        = ($urandom % 4) == 0;
         wr_addr        = pick_addr();
         br_rd_rdy      = $urandom % 2;
         br_ret_data    = $urandom;
         if (m_busy && m_issued && ($urandom % 4) != 0) begin
            br_ret_valid = 1;
            br_ret_id    = (($urandom % 16) == 0) ? 4'($urandom) : m_id;
            br_ret_last  = (m_beats == beats_of(m_type) - 1);
            if (($urandom % 16) == 0) br_ret_last = ~br_ret_last;
         end else begin
            br_ret_valid = ($urandom % 20) == 0;
            br_ret_id    = 4'($urandom % 2);
            br_ret_last  = $urandom % 2;
         end
         settle;
         if (($urandom % 300) == 0) do_reset;
         else adv;
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
